// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        CSUM
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader: length byte, N big-endian 16-bit words, XOR checksum byte.
// Each assembled word is written straight into the instruction memory's write port.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [CNT_W-1:0]    n_words;
    logic [BYTE_W-1:0]   csum;
    logic                take;

    assign take = in_valid && in_ready;

    // in_ready and busy are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            addr       <= '0;
            n_words    <= '0;
            csum       <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LEN;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        addr       <= '0;
                        csum       <= '0;
                    end
                end
                LEN: begin
                    if (take) begin
                        if (in_data == '0 || 32'(in_data) > MAX_WORDS) begin
                            err      <= 1'b1;
                            state    <= IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            n_words <= CNT_W'(in_data);
                            state   <= HI;
                        end
                    end
                end
                HI: begin
                    if (take) begin
                        wr_data[DATA_W-1 -: BYTE_W] <= in_data;
                        csum  <= csum ^ in_data;
                        state <= LO;
                    end
                end
                LO: begin
                    if (take) begin
                        wr_data[BYTE_W-1:0] <= in_data;
                        csum       <= csum ^ in_data;
                        wr_en      <= 1'b1;
                        wr_addr    <= addr;
                        addr       <= addr + ADDR_W'(1);
                        word_count <= word_count + CNT_W'(1);
                        // The counter never wraps into a second pass: the last word always leads to CSUM.
                        state      <= (word_count + CNT_W'(1) == n_words) ? CSUM : HI;
                    end
                end
                CSUM: begin
                    if (take) begin
                        if (in_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    typedef logic [ADDR_W+DATA_W-1:0] wr_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    wr_t got_q[$];
    wr_t exp_q[$];
    bit  exp_done;
    bit  exp_err;
    int  exp_wc;
    logic            obs_done, obs_err, obs_busy;
    logic [ADDR_W:0] obs_wc;
    bit  noise = 0;

    // Every cycle wr_en is high counts as one write.
    always @(negedge clk) if (wr_en === 1'b1) got_q.push_back({wr_addr, wr_data});

    // Reference: what a complete stream must produce, from the protocol rules alone.
    function automatic void model(input logic [7:0] s[$]);
        int n;
        logic [7:0] x;
        n = int'(s[0]);
        x = 8'h00;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_wc   = 0;
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ADDR_W'(i), s[1+2*i], s[2+2*i]});
            x = x ^ s[1+2*i] ^ s[2+2*i];
        end
        exp_wc = n;
        if (s[2*n+1] == x) exp_done = 1;
        else exp_err = 1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int guard = 0;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            if (guard > 500) begin
                $display("FAIL handshake_timeout byte=%h in_ready=%b want 1", b, in_ready);
                fails++;
                tests++;
                return;
            end
            guard++;
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                if (noise && busy === 1'b1 && $urandom_range(3) == 0) start = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready === 1'b1) return;
            end
        end
    endtask

    task automatic run_stream(input logic [7:0] s[$], input int gap_pct);
        got_q.delete();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        foreach (s[i]) send_byte(s[i], gap_pct);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        obs_done = done;
        obs_err  = err;
        obs_busy = busy;
        obs_wc   = word_count;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b want 0", in_ready); fails++; end
        tests++; if (wr_en !== 1'b0) begin $display("FAIL reset_wr_en got %b want 0", wr_en); fails++; end
        tests++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); fails++; end
        tests++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); fails++; end
        tests++; if (err !== 1'b0) begin $display("FAIL reset_err got %b want 0", err); fails++; end
        tests++; if (wr_addr !== '0) begin $display("FAIL reset_wr_addr got %h want 0", wr_addr); fails++; end
        tests++; if (wr_data !== '0) begin $display("FAIL reset_wr_data got %h want 0", wr_data); fails++; end
        tests++; if (word_count !== '0) begin $display("FAIL reset_word_count got %h want 0", word_count); fails++; end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] s[$];
        for (int k = 0; k < 2; k++) begin
            s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, (k == 0) ? 8'h40 : 8'h41};
            model(s);
            run_stream(s, 0);
            tests++; if (got_q.size() != exp_q.size()) begin $display("FAIL basic%0d_nwrites got %0d want %0d", k, got_q.size(), exp_q.size()); fails++; end
            else foreach (exp_q[i]) begin
                tests++; if (got_q[i] !== exp_q[i]) begin $display("FAIL basic%0d_write%0d got %h want %h", k, i, got_q[i], exp_q[i]); fails++; end
            end
            tests++; if (obs_done !== exp_done) begin $display("FAIL basic%0d_done got %b want %b", k, obs_done, exp_done); fails++; end
            tests++; if (obs_err !== exp_err) begin $display("FAIL basic%0d_err got %b want %b", k, obs_err, exp_err); fails++; end
            tests++; if (obs_busy !== 1'b0) begin $display("FAIL basic%0d_busy got %b want 0", k, obs_busy); fails++; end
            tests++; if (obs_wc !== (ADDR_W+1)'(exp_wc)) begin $display("FAIL basic%0d_word_count got %h want %h", k, obs_wc, exp_wc); fails++; end
            tests++; if (done !== exp_done || err !== exp_err) begin $display("FAIL basic%0d_sticky got %b%b want %b%b", k, done, err, exp_done, exp_err); fails++; end
        end
    endtask

    task automatic test_bad_length;
        logic [7:0] s[$];
        for (int k = 0; k < 2; k++) begin
            s = '{(k == 0) ? 8'h00 : 8'h21};
            model(s);
            run_stream(s, 0);
            tests++; if (got_q.size() != 0) begin $display("FAIL badlen%0d_nwrites got %0d want 0", k, got_q.size()); fails++; end
            tests++; if (obs_err !== 1'b1) begin $display("FAIL badlen%0d_err got %b want 1", k, obs_err); fails++; end
            tests++; if (obs_done !== 1'b0) begin $display("FAIL badlen%0d_done got %b want 0", k, obs_done); fails++; end
            tests++; if (obs_busy !== 1'b0) begin $display("FAIL badlen%0d_busy got %b want 0", k, obs_busy); fails++; end
            tests++; if (in_ready !== 1'b0) begin $display("FAIL badlen%0d_in_ready got %b want 0", k, in_ready); fails++; end
        end
    endtask

    task automatic test_full_depth;
        logic [7:0] s[$];
        logic [7:0] x = 8'h00;
        s.push_back(8'h20);
        for (int i = 0; i < 32; i++) begin
            s.push_back(8'h00);
            s.push_back(8'(i));
            x = x ^ 8'(i);
        end
        s.push_back(x);
        model(s);
        run_stream(s, 0);
        tests++; if (got_q.size() != exp_q.size()) begin $display("FAIL full_nwrites got %0d want %0d", got_q.size(), exp_q.size()); fails++; end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin $display("FAIL full_write%0d got %h want %h", i, got_q[i], exp_q[i]); fails++; end
        end
        if (got_q.size() > 0) begin
            tests++; if (got_q[$][ADDR_W+DATA_W-1:DATA_W] !== 5'h1F) begin $display("FAIL full_last_addr got %h want 1f", got_q[$][ADDR_W+DATA_W-1:DATA_W]); fails++; end
        end
        tests++; if (obs_done !== 1'b1 || obs_err !== 1'b0) begin $display("FAIL full_status got done=%b err=%b want done=1 err=0", obs_done, obs_err); fails++; end
        tests++; if (obs_wc !== 6'h20) begin $display("FAIL full_word_count got %h want 20", obs_wc); fails++; end
    endtask

    task automatic test_reset_mid_load;
        logic [7:0] s[$];
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        tests++; if (got_q.size() != 1) begin $display("FAIL midrst_nwrites got %0d want 1", got_q.size()); fails++; end
        tests++; if ({in_ready, wr_en, busy, done, err} !== 5'b0) begin $display("FAIL midrst_flags got %b want 00000", {in_ready, wr_en, busy, done, err}); fails++; end
        tests++; if (wr_addr !== '0 || wr_data !== '0 || word_count !== '0) begin $display("FAIL midrst_buses got %h/%h/%h want 0/0/0", wr_addr, wr_data, word_count); fails++; end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (got_q.size() != 1) begin $display("FAIL midrst_pending_write got %0d want 1", got_q.size()); fails++; end
        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        model(s);
        run_stream(s, 0);
        tests++; if (got_q.size() != exp_q.size()) begin $display("FAIL midrst_restart_nwrites got %0d want %0d", got_q.size(), exp_q.size()); fails++; end
        else foreach (exp_q[i]) begin
            tests++; if (got_q[i] !== exp_q[i]) begin $display("FAIL midrst_restart_write%0d got %h want %h", i, got_q[i], exp_q[i]); fails++; end
        end
        tests++; if (obs_done !== 1'b1 || obs_err !== 1'b0) begin $display("FAIL midrst_restart_status got done=%b err=%b want done=1 err=0", obs_done, obs_err); fails++; end
    endtask

    task automatic test_gaps_random;
        logic [7:0] s[$];
        logic [7:0] x;
        logic [7:0] b;
        int n;
        noise = 1;
        for (int k = 0; k < 6; k++) begin
            s.delete();
            x = 8'h00;
            n = (k == 0) ? 2 : int'($urandom_range(1, 32));
            s.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) begin
                b = (k == 0) ? ((i == 0) ? 8'h12 : (i == 1) ? 8'h34 : (i == 2) ? 8'hAB : 8'hCD) : 8'($urandom);
                s.push_back(b);
                x = x ^ b;
            end
            s.push_back(($urandom_range(3) == 0) ? (x ^ 8'h5A) : x);
            model(s);
            run_stream(s, 60);
            tests++; if (got_q.size() != exp_q.size()) begin $display("FAIL gaps%0d_nwrites got %0d want %0d", k, got_q.size(), exp_q.size()); fails++; end
            else foreach (exp_q[i]) begin
                tests++; if (got_q[i] !== exp_q[i]) begin $display("FAIL gaps%0d_write%0d got %h want %h", k, i, got_q[i], exp_q[i]); fails++; end
            end
            tests++; if (obs_done !== exp_done || obs_err !== exp_err) begin $display("FAIL gaps%0d_status got done=%b err=%b want done=%b err=%b", k, obs_done, obs_err, exp_done, exp_err); fails++; end
            tests++; if (obs_wc !== (ADDR_W+1)'(exp_wc)) begin $display("FAIL gaps%0d_word_count got %h want %h", k, obs_wc, exp_wc); fails++; end
            tests++; if (obs_busy !== 1'b0) begin $display("FAIL gaps%0d_busy got %b want 0", k, obs_busy); fails++; end
        end
        noise = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_length();
        test_full_depth();
        test_reset_mid_load();
        test_gaps_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 16, instruction width; fixed at 2 bytes per word.
REQ-003 SHALL have port clk  input  1  clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse to begin a load session.
REQ-006 SHALL have port in_valid  input  1  byte-stream source has a byte.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  loader accepts the byte this cycle.
REQ-009 SHALL have port wr_en  output  1  write strobe to the instruction-memory write port.
REQ-010 SHALL have port wr_addr  output  ADDR_W  write address.
REQ-011 SHALL have port wr_data  output  DATA_W  write instruction word.
REQ-012 SHALL have port busy  output  1  session in progress.
REQ-013 SHALL have port done  output  1  session ended with checksum match (sticky).
REQ-014 SHALL have port err  output  1  session ended with bad length or checksum (sticky).
REQ-015 SHALL have port word_count  output  ADDR_W+1  words written in the current/last session.

Function
REQ-016 SHALL transfer a byte only in a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL implement states IDLE, LEN, HI, LO, CSUM; in_ready = 1 only in LEN, HI, LO, CSUM.
REQ-018 SHALL move IDLE -> LEN on start, clearing done, err, word_count, the address counter and the checksum; start outside IDLE is ignored.
REQ-019 SHALL in LEN take the byte as word count N; N = 0 or N > 2**ADDR_W -> err = 1, IDLE, no writes; else store N, go to HI.
REQ-020 SHALL in HI latch the byte as wr_data[15:8], go to LO.
REQ-021 SHALL in LO latch the byte as wr_data[7:0] and assert wr_en for exactly the next cycle, with wr_addr = current address counter, wr_data = full word.
REQ-022 SHALL after each LO byte increment address counter and word_count; go to CSUM when word_count reaches N, else HI.
REQ-023 SHALL keep a running 8-bit XOR checksum of every HI and LO byte (not the length byte).
REQ-024 SHALL in CSUM compare the received byte to the running XOR; match -> done = 1, mismatch -> err = 1; either way return to IDLE the following cycle.
REQ-025 SHALL assert done/err the cycle after the final byte is accepted and hold it until the next accepted start or reset.
REQ-026 SHALL leave already-written words in memory on checksum error (no rollback).
REQ-027 SHALL hold busy = 1 in every state except IDLE.
REQ-028 SHALL not wrap the address: N = 2**ADDR_W writes addresses 0..2**ADDR_W-1 then enters CSUM.
REQ-029 SHALL tolerate in_valid gaps of any length in any receiving state with no state change.

Reset
REQ-030 SHALL on reset = 0 at posedge go to IDLE and set in_ready, wr_en, busy, done, err = 0, wr_addr, wr_data, word_count, checksum = 0.
REQ-031 SHALL abort a session in progress on reset mid-load, suppressing any pending wr_en.

Structure
REQ-032 SHALL place the state enum typedef and the byte width constant in a shared package imem_pkg.
REQ-033 SHALL be a single module with no sub-modules; wr_* drive a writable imem variant's write port directly.

Verification
REQ-034 SHALL cover: start, bytes 02,12,34,AB,CD,checksum 40 -> writes 0:1234, 1:ABCD, done = 1, err = 0, word_count = 2.
REQ-035 SHALL cover: same stream with checksum 41 -> both writes occur, err = 1, done = 0.
REQ-036 SHALL cover: length byte 00, then length byte 21 (33) -> err = 1, no wr_en, busy = 0 next cycle.
REQ-037 SHALL cover: N = 20 (32 words), data = address index -> last write at address 1F, done = 1, word_count = 20 (hex).
REQ-038 SHALL cover: reset low after HI byte of word 1 -> no wr_en for that word, all outputs zero, new start succeeds.
REQ-039 SHALL cover: in_valid toggled randomly and start pulsed mid-session -> identical writes to the gap-free run, start ignored.
